wb_decoder: RTL and testbench
=============================

WB_DECODER -- requirements
Module: wb_decoder

Interface
REQ-001 SHALL have parameter NS, default 4: number of Wishbone slave ports (1..8).
REQ-002 SHALL have parameter AW, default 30: word-address width.
REQ-003 SHALL have parameter DW, default 32: data width (multiple of 8).
REQ-004 SHALL have parameter SLAVE_BASE, default {30'h3FFF_FC09, 30'h3FFF_FC08, 30'h3FFF_FC00, 30'h0}: packed NS*AW per-slave base words, slave 0 in LSBs.
REQ-005 SHALL have parameter SLAVE_MASK, default {3{30'h3FFF_FFFF}}, 30'h3FFF_C000}: packed NS*AW compare masks.
REQ-006 SHALL have parameter MAX_OUT, default 4: maximum outstanding accepted requests (1..15).
REQ-007 SHALL have parameter TIMEOUT, default 255: idle-response cycles before forced error (1..65535).
REQ-008 SHALL have ports i_clk in 1 (system clock) and i_resetn in 1 (reset).
REQ-009 SHALL have master-side inputs i_m_cyc 1, i_m_stb 1, i_m_we 1, i_m_addr AW, i_m_data DW, i_m_sel DW/8.
REQ-010 SHALL have master-side outputs o_m_ack 1, o_m_err 1, o_m_stall 1, o_m_data DW.
REQ-011 SHALL have slave-side outputs o_s_cyc NS, o_s_stb NS (one-hot per slave), plus broadcast o_s_we 1, o_s_addr AW, o_s_data DW, o_s_sel DW/8.
REQ-012 SHALL have slave-side inputs i_s_ack NS, i_s_err NS, i_s_stall NS, i_s_data NS*DW.
REQ-013 Reset SHALL be i_resetn: asynchronous assert, active-low; one clock, i_clk, rising edge.

Function
REQ-014 Slave k SHALL match when (i_m_addr & MASK[k]) == (BASE[k] & MASK[k]); on multiple matches the lowest k SHALL win; no match = unmapped.
REQ-015 o_s_we/addr/data/sel SHALL be combinational pass-throughs of master inputs; o_s_cyc[k] SHALL equal i_m_cyc for all k.
REQ-016 A request SHALL be issued when i_m_cyc & i_m_stb & !o_m_stall; o_s_stb[k] SHALL be high only for the matched slave and only when not blocked by REQ-017.
REQ-017 o_m_stall SHALL be 1 when: matched slave i_s_stall is 1; or outstanding count == MAX_OUT; or count > 0 and new target (slave index or unmapped) differs from the target register; or an unmapped request is issued while count > 0.
REQ-018 Outstanding count SHALL increment on issue, decrement on any accepted response (ack or err), and hold when both occur in the same cycle; it SHALL never exceed MAX_OUT nor underflow.
REQ-019 Target register SHALL load the issued target on each issue; it is used only while count > 0.
REQ-020 Responses SHALL be registered: i_s_ack/i_s_err of the target slave at cycle t SHALL appear on o_m_ack/o_m_err at t+1 with o_m_data = that slave's i_s_data sampled at t; otherwise o_m_data SHALL be 0.
REQ-021 Responses from non-target slaves, or with count == 0, SHALL be discarded.
REQ-022 If ack and err assert together, o_m_err SHALL win and o_m_ack SHALL be 0.
REQ-023 An unmapped issue at cycle t SHALL produce o_m_err = 1 for exactly one cycle at t+1 and no slave strobe.
REQ-024 Timeout counter SHALL reset to 0 on any accepted response or when count == 0, else increment; reaching TIMEOUT SHALL pulse o_m_err for one cycle and clear count to 0.
REQ-025 i_m_cyc falling SHALL clear count and timeout counter next edge; no response pulse SHALL be generated for abandoned requests.

Reset
REQ-026 While i_resetn = 0: o_m_ack, o_m_err, o_m_data, count, target, timeout counter SHALL be 0; o_s_stb SHALL be 0 regardless of master inputs.
REQ-027 Reset asserted mid-transaction SHALL drop all outstanding state; the first edge after release SHALL accept new requests normally.

Verification
REQ-028 Read addr 0x0000_0010 (slave 0), ack 2 cycles later with data 0xDEAD_BEEF -> o_s_stb=4'b0001 for one cycle; o_m_ack one cycle after slave ack, o_m_data=0xDEAD_BEEF.
REQ-029 Back-to-back 5 reads to slave 0 with slave never acking, MAX_OUT=4 -> 4 issued, 5th stalled; after TIMEOUT=255 idle cycles o_m_err pulses once, count returns 0, 5th then issues.
REQ-030 Read slave 0 outstanding, then request to 0x3FFF_FC00 (slave 1) -> o_m_stall=1 until slave 0 ack accepted, then slave 1 strobed.
REQ-031 Request to 0x0001_0000 (unmapped) with count 0 -> no o_s_stb, o_m_err=1 exactly one cycle later, o_m_ack=0.
REQ-032 Slave 0 asserts i_s_ack and i_s_err same cycle -> o_m_err=1, o_m_ack=0, count decrements by 1.
REQ-033 i_resetn low for 1 cycle with 3 requests outstanding -> all outputs 0 immediately; late slave acks after release produce no o_m_ack.

Source files
------------

// File: rtl/wb_decoder_if.sv
// ----------------------------------------------------------------------------
// wb_decoder_if
// Bundle of the master-side and slave-side Wishbone pipelined signals seen by
// wb_decoder. Signal names keep the decoder's i_/o_ view of each wire.
//   i_m_*  : master request into the decoder (cyc, stb, we, addr, data, sel)
//   o_m_*  : registered response back to the master (ack, err, data) + stall
//   o_s_*  : per-slave cyc/stb plus broadcast we/addr/data/sel
//   i_s_*  : per-slave ack/err/stall and packed read data (slave 0 in LSBs)
// Modports:
//   slave  : decoder side (consumes i_*, drives o_*)
//   master : environment side (drives i_*, consumes o_*)
// ----------------------------------------------------------------------------
interface wb_decoder_if #(
    parameter int NS = 4,
    parameter int AW = 30,
    parameter int DW = 32
);
    logic                 i_m_cyc;
    logic                 i_m_stb;
    logic                 i_m_we;
    logic [AW-1:0]        i_m_addr;
    logic [DW-1:0]        i_m_data;
    logic [DW/8-1:0]      i_m_sel;
    logic                 o_m_ack;
    logic                 o_m_err;
    logic                 o_m_stall;
    logic [DW-1:0]        o_m_data;

    logic [NS-1:0]        o_s_cyc;
    logic [NS-1:0]        o_s_stb;
    logic                 o_s_we;
    logic [AW-1:0]        o_s_addr;
    logic [DW-1:0]        o_s_data;
    logic [DW/8-1:0]      o_s_sel;
    logic [NS-1:0]        i_s_ack;
    logic [NS-1:0]        i_s_err;
    logic [NS-1:0]        i_s_stall;
    logic [NS*DW-1:0]     i_s_data;

    modport slave (
        input  i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data, i_m_sel,
        output o_m_ack, o_m_err, o_m_stall, o_m_data,
        output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
        input  i_s_ack, i_s_err, i_s_stall, i_s_data
    );

    modport master (
        output i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data, i_m_sel,
        input  o_m_ack, o_m_err, o_m_stall, o_m_data,
        input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
        output i_s_ack, i_s_err, i_s_stall, i_s_data
    );
endinterface

// File: rtl/wb_decoder.sv
// ----------------------------------------------------------------------------
// wb_decoder
// One-master to NS-slave Wishbone pipelined address decoder. Tracks up to
// MAX_OUT outstanding requests to a single target at a time, registers the
// target's response back to the master, answers unmapped requests with an
// error and forces an error if the target goes quiet for TIMEOUT cycles.
// Ports:
//   i_clk     : clock, rising edge
//   i_resetn  : asynchronous active-low reset
//   bus       : wb_decoder_if.slave (master request/response, slave fan-out)
// ----------------------------------------------------------------------------
module wb_decoder #(
    parameter int               NS         = 4,
    parameter int               AW         = 30,
    parameter int               DW         = 32,
    parameter logic [NS*AW-1:0] SLAVE_BASE = {30'h3FFF_FC09, 30'h3FFF_FC08,
                                              30'h3FFF_FC00, 30'h0},
    parameter logic [NS*AW-1:0] SLAVE_MASK = {{3{30'h3FFF_FFFF}}, 30'h3FFF_C000},
    parameter int               MAX_OUT    = 4,
    parameter int               TIMEOUT    = 255
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    wb_decoder_if.slave bus
);

    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam int CW = 4;
    localparam int TW = 16;

    typedef struct packed {
        logic          ack;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          r_rsp;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_tgt_idx;
    logic          r_tgt_unm;
    logic [TW-1:0] r_tmo;

    logic [NS-1:0] w_hit_vec;
    logic          w_hit;
    logic [IW-1:0] w_idx;
    logic          w_cnt_nz;
    logic          w_tgt_diff;
    logic          w_stall;
    logic          w_issue;
    logic          w_iss_map;
    logic          w_iss_unm;
    logic [NS-1:0] w_stb;
    logic          w_s_ack;
    logic          w_s_err;
    logic [DW-1:0] w_s_data;
    logic          w_rsp_ok;
    logic          w_rsp_ack;
    logic          w_rsp_err;
    logic          w_rsp;
    logic          w_tmo_fire;

    // Per-slave address compare
    for (genvar k = 0; k < NS; k++) begin : g_match
        assign w_hit_vec[k] =
            ((bus.i_m_addr & SLAVE_MASK[k*AW +: AW]) ==
             (SLAVE_BASE[k*AW +: AW] & SLAVE_MASK[k*AW +: AW]));
    end

    // Descending scan so the lowest matching index is the last one written
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (w_hit_vec[k]) begin
                w_hit = 1'b1;
                w_idx = IW'(k);
            end
        end
    end

    assign w_cnt_nz   = (r_cnt != '0);
    assign w_tgt_diff = (!w_hit != r_tgt_unm) || (w_hit && (w_idx != r_tgt_idx));

    // Only one target may have requests in flight, so a change of target
    // waits until every outstanding response has come back.
    assign w_stall = (w_hit && bus.i_s_stall[w_idx])
                   || (r_cnt == CW'(MAX_OUT))
                   || (w_cnt_nz && w_tgt_diff)
                   || (w_cnt_nz && !w_hit);

    assign w_issue   = i_resetn && bus.i_m_cyc && bus.i_m_stb && !w_stall;
    assign w_iss_map = w_issue && w_hit;
    assign w_iss_unm = w_issue && !w_hit;

    always_comb begin
        w_stb = '0;
        for (int k = 0; k < NS; k++) begin
            w_stb[k] = w_iss_map && (w_idx == IW'(k));
        end
    end

    // Response path from the current target only
    always_comb begin
        w_s_data = '0;
        for (int k = 0; k < NS; k++) begin
            if (r_tgt_idx == IW'(k)) w_s_data = bus.i_s_data[k*DW +: DW];
        end
    end

    assign w_s_ack    = bus.i_s_ack[r_tgt_idx];
    assign w_s_err    = bus.i_s_err[r_tgt_idx];
    assign w_rsp_ok   = bus.i_m_cyc && w_cnt_nz && !r_tgt_unm;
    assign w_rsp_ack  = w_rsp_ok && w_s_ack && !w_s_err;
    assign w_rsp_err  = w_rsp_ok && w_s_err;
    assign w_rsp      = w_rsp_ack || w_rsp_err;
    assign w_tmo_fire = bus.i_m_cyc && w_cnt_nz && !w_rsp && (r_tmo == TW'(TIMEOUT - 1));

    // An unmapped issue is answered in the same edge it is accepted, so it
    // counts as issue and response together and leaves r_cnt unchanged.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rsp     <= '0;
            r_cnt     <= '0;
            r_tgt_idx <= '0;
            r_tgt_unm <= 1'b0;
            r_tmo     <= '0;
        end else begin
            r_rsp.ack  <= w_rsp_ack;
            r_rsp.err  <= w_rsp_err || w_iss_unm || w_tmo_fire;
            r_rsp.data <= w_rsp ? w_s_data : '0;

            if (w_issue) begin
                r_tgt_idx <= w_idx;
                r_tgt_unm <= !w_hit;
            end

            if (!bus.i_m_cyc) begin
                r_cnt <= '0;
            end else if (w_tmo_fire) begin
                // Abandoned requests are dropped; a same-cycle issue survives
                r_cnt <= w_iss_map ? CW'(1) : '0;
            end else if (w_iss_map && !w_rsp) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_iss_map && w_rsp) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (!bus.i_m_cyc || !w_cnt_nz || w_rsp || w_tmo_fire) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    assign bus.o_m_ack   = r_rsp.ack;
    assign bus.o_m_err   = r_rsp.err;
    assign bus.o_m_data  = r_rsp.data;
    assign bus.o_m_stall = w_stall;

    assign bus.o_s_cyc  = {NS{bus.i_m_cyc}};
    assign bus.o_s_stb  = w_stb;
    assign bus.o_s_we   = bus.i_m_we;
    assign bus.o_s_addr = bus.i_m_addr;
    assign bus.o_s_data = bus.i_m_data;
    assign bus.o_s_sel  = bus.i_m_sel;

endmodule

// File: tb/tb_wb_decoder.sv
// ----------------------------------------------------------------------------
// tb_wb_decoder
// Directed scenarios followed by a randomized phase. A transaction-level
// model (queue of outstanding targets + idle cycle count) predicts stall,
// strobes and the registered master response every cycle.
// ----------------------------------------------------------------------------
module tb_wb_decoder;
    localparam int NS = 4, AW = 30, DW = 32, MAX_OUT = 4, TIMEOUT = 255;
    localparam logic [AW-1:0] BASE [NS] = '{30'h0, 30'h3FFF_FC00, 30'h3FFF_FC08, 30'h3FFF_FC09};
    localparam logic [AW-1:0] MASK [NS] = '{30'h3FFF_C000, 30'h3FFF_FFFF, 30'h3FFF_FFFF, 30'h3FFF_FFFF};

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_decoder_if #(.NS(NS), .AW(AW), .DW(DW)) bif ();

    wb_decoder #(.NS(NS), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
        .i_clk    (clk),
        .i_resetn (rstn),
        .bus      (bif)
    );

    int checks = 0;
    int errors = 0;
    int pend[$];
    int idle = 0;
    logic e_ack = 1'b0, e_err = 1'b0;
    logic [DW-1:0] e_data = '0;
    logic [DW-1:0] sdat [NS];
    logic [NS-1:0] last_stb;
    logic          last_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [AW-1:0] a);
        for (int k = 0; k < NS; k++)
            if ((a & MASK[k]) == (BASE[k] & MASK[k])) return k;
        return NS;
    endfunction

    task automatic set_req(input logic cyc, input logic stb, input logic [AW-1:0] addr);
        bif.i_m_cyc  = cyc;
        bif.i_m_stb  = stb;
        bif.i_m_addr = addr;
        bif.i_m_we   = 1'b0;
    endtask

    // One clock: compare at the falling edge, then advance the model.
    task automatic step();
        int t, tg;
        bit req, stall, issue, rsp, fire;
        logic [NS-1:0] stb_e;
        for (int k = 0; k < NS; k++) bif.i_s_data[k*DW +: DW] = sdat[k];
        @(negedge clk);
        t     = decode(bif.i_m_addr);
        req   = bif.i_m_cyc && bif.i_m_stb;
        stall = (t < NS && bif.i_s_stall[t]) || (pend.size() == MAX_OUT)
              || (pend.size() > 0 && t != pend[$]) || (t == NS && pend.size() > 0);
        issue = req && !stall;
        stb_e = (issue && t < NS) ? NS'(1 << t) : '0;
        last_stb   = bif.o_s_stb;
        last_stall = bif.o_m_stall;
        chk("stall", 64'(bif.o_m_stall), 64'(stall));
        chk("s_stb", 64'(bif.o_s_stb), 64'(stb_e));
        chk("m_ack", 64'(bif.o_m_ack), 64'(e_ack));
        chk("m_err", 64'(bif.o_m_err), 64'(e_err));
        chk("m_data", 64'(bif.o_m_data), 64'(e_data));
        chk("s_cyc", 64'(bif.o_s_cyc), 64'({NS{bif.i_m_cyc}}));
        chk("s_addr", 64'(bif.o_s_addr), 64'(bif.i_m_addr));

        tg   = (pend.size() > 0) ? pend[0] : 0;
        rsp  = bif.i_m_cyc && pend.size() > 0 && (bif.i_s_ack[tg] || bif.i_s_err[tg]);
        fire = bif.i_m_cyc && pend.size() > 0 && !rsp && idle == TIMEOUT - 1;
        e_ack  = rsp && bif.i_s_ack[tg] && !bif.i_s_err[tg];
        e_err  = (rsp && bif.i_s_err[tg]) || (issue && t == NS) || fire;
        e_data = rsp ? sdat[tg] : '0;
        if (!bif.i_m_cyc) begin
            pend.delete(); idle = 0;
        end else if (fire) begin
            pend.delete(); idle = 0;
            if (issue && t < NS) pend.push_back(t);
        end else begin
            idle = (pend.size() == 0 || rsp) ? 0 : idle + 1;
            if (rsp) void'(pend.pop_front());
            if (issue && t < NS) pend.push_back(t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #1;
        chk("rst_ack", 64'(bif.o_m_ack), 64'(0));
        chk("rst_err", 64'(bif.o_m_err), 64'(0));
        chk("rst_data", 64'(bif.o_m_data), 64'(0));
        chk("rst_stb", 64'(bif.o_s_stb), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_stb_hold", 64'(bif.o_s_stb), 64'(0));
        rstn = 1'b1;
        pend.delete(); idle = 0;
        e_ack = 1'b0; e_err = 1'b0; e_data = '0;
    endtask

    initial begin
        int n_iss, n_err;
        for (int k = 0; k < NS; k++) sdat[k] = '0;
        set_req(1'b0, 1'b0, '0);
        bif.i_m_data = '0; bif.i_m_sel = '1;
        bif.i_s_ack = '0; bif.i_s_err = '0; bif.i_s_stall = '0; bif.i_s_data = '0;
        set_req(1'b1, 1'b1, 30'h10);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", 64'(bif.o_m_ack), 64'(0));
        chk("reset_err", 64'(bif.o_m_err), 64'(0));
        chk("reset_stb", 64'(bif.o_s_stb), 64'(0));
        rstn = 1'b1;

        // Single read to slave 0, ack two cycles later
        set_req(1'b1, 1'b1, 30'h10); step();
        chk("r028_stb", 64'(last_stb), 64'(4'b0001));
        set_req(1'b1, 1'b0, 30'h10); step();
        bif.i_s_ack = 4'b0001; sdat[0] = 32'hDEAD_BEEF; step();
        bif.i_s_ack = '0;
        chk("r028_ack", 64'(bif.o_m_ack), 64'(1));
        chk("r028_data", 64'(bif.o_m_data), 64'(32'hDEAD_BEEF));
        step();

        // Five reads to a silent slave 0: four issue, timeout, fifth issues
        n_iss = 0; n_err = 0;
        set_req(1'b1, 1'b1, 30'h20);
        for (int i = 0; i < 300; i++) begin
            if (n_iss >= 5) bif.i_m_stb = 1'b0;
            step();
            if (last_stb != '0) n_iss++;
            if (i == 5) chk("r029_stall", 64'(last_stall), 64'(1));
            if (bif.o_m_err) n_err++;
        end
        chk("r029_issued", 64'(n_iss), 64'(5));
        chk("r029_errs", 64'(n_err), 64'(1));
        set_req(1'b0, 1'b0, 30'h20); step();   // abandon the fifth
        set_req(1'b1, 1'b0, 30'h20); repeat (3) step();

        // Target switch waits for the slave 0 response
        set_req(1'b1, 1'b1, 30'h10); step();
        set_req(1'b1, 1'b1, 30'h3FFF_FC00); step(); step();
        chk("r030_stall", 64'(last_stall), 64'(1));
        bif.i_s_ack = 4'b0001; sdat[0] = 32'h1234_5678; step();
        bif.i_s_ack = '0; step();
        chk("r030_s1_stb", 64'(last_stb), 64'(4'b0010));
        set_req(1'b1, 1'b0, 30'h0);
        bif.i_s_ack = 4'b0010; sdat[1] = 32'hCAFE_0001; step();
        bif.i_s_ack = '0; step();

        // Unmapped request
        set_req(1'b1, 1'b1, 30'h0001_0000); step();
        chk("r031_stb", 64'(last_stb), 64'(0));
        chk("r031_err", 64'(bif.o_m_err), 64'(1));
        chk("r031_ack", 64'(bif.o_m_ack), 64'(0));
        set_req(1'b1, 1'b0, 30'h0); step();

        // Ack and err together
        set_req(1'b1, 1'b1, 30'h40); step(); step();
        set_req(1'b1, 1'b0, 30'h40);
        bif.i_s_ack = 4'b0001; bif.i_s_err = 4'b0001; step();
        bif.i_s_ack = '0; bif.i_s_err = '0;
        chk("r032_err", 64'(bif.o_m_err), 64'(1));
        chk("r032_ack", 64'(bif.o_m_ack), 64'(0));
        bif.i_s_ack = 4'b0001; step();           // retires the second one
        bif.i_s_ack = '0;
        chk("r032_ack2", 64'(bif.o_m_ack), 64'(1));
        step();

        // Reset with three outstanding, late acks ignored
        set_req(1'b1, 1'b1, 30'h10); repeat (3) step();
        pulse_reset();
        set_req(1'b1, 1'b0, 30'h10);
        bif.i_s_ack = 4'b0001; step();
        bif.i_s_ack = '0; step();
        chk("r033_noack", 64'(bif.o_m_ack), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a;
            case ($urandom_range(0, 6))
                0: a = AW'($urandom_range(0, 16383));
                1: a = 30'h3FFF_FC00;
                2: a = 30'h3FFF_FC08;
                3: a = 30'h3FFF_FC09;
                4: a = 30'h0001_0000;
                5: a = AW'($urandom);
                default: a = 30'h10;
            endcase
            set_req(($urandom_range(0, 19) != 0), $urandom_range(0, 1) == 1, a);
            bif.i_s_ack   = NS'($urandom) & NS'($urandom);
            bif.i_s_err   = NS'($urandom) & NS'($urandom) & NS'($urandom);
            bif.i_s_stall = NS'($urandom) & NS'($urandom) & NS'($urandom);
            for (int k = 0; k < NS; k++) sdat[k] = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
